// File: rtl/wbu_pkg.sv
// Shared constants and types for the byte-stream Wishbone command master.
package wbu_pkg;

   // Command opcodes received over RX
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   // Response header bytes returned over TX
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_READ = 8'h52;
   localparam logic [7:0] RSP_ERR  = 8'h3F;
   localparam logic [7:0] RSP_TMO  = 8'h54;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_DATA     = 3'd2,
      ST_BUS_REQ  = 3'd3,
      ST_BUS_WAIT = 3'd4,
      ST_RESP     = 3'd5
   } wbu_state_e;

   // True when the byte starts a valid read or write command
   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/wbu_resp_serializer.sv
// Emits a header byte optionally followed by a 32-bit word (MSB first)
// over a valid/busy handshake; o_done flags acceptance of the last byte.
module wbu_resp_serializer
   import wbu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [7:0]  i_hdr,
   input  logic [31:0] i_word,
   input  logic [2:0]  i_len,
   input  logic        i_tx_busy,
   output logic        o_tx_stb,
   output logic [7:0]  o_tx_data,
   output logic        o_done
);

   logic        stb_q, stb_d;
   logic [7:0]  data_q, data_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  left_q, left_d;
   logic        xfer_s;

   assign xfer_s    = stb_q && !i_tx_busy;
   assign o_done    = xfer_s && (left_q <= 3'd1);
   assign o_tx_stb  = stb_q;
   assign o_tx_data = data_q;

   // Next-state: load a new response, or advance one byte per accepted transfer
   always_comb begin
      stb_d  = stb_q;
      data_d = data_q;
      word_d = word_q;
      left_d = left_q;
      if (i_load) begin
         stb_d  = 1'b1;
         data_d = i_hdr;
         word_d = i_word;
         left_d = i_len;
      end else if (xfer_s) begin
         if (left_q <= 3'd1) begin
            stb_d  = 1'b0;
            left_d = 3'd0;
         end else begin
            data_d = word_q[31:24];
            word_d = {word_q[23:0], 8'h00};
            left_d = left_q - 3'd1;
         end
      end else begin
         stb_d = stb_q;
      end
   end

   // Response registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stb_q  <= 1'b0;
         data_q <= 8'h00;
         word_q <= 32'h0000_0000;
         left_q <= 3'd0;
      end else begin
         stb_q  <= stb_d;
         data_q <= data_d;
         word_q <= word_d;
         left_q <= left_d;
      end
   end

endmodule

// File: rtl/wbu_cmd_master.sv
// Collects W/R command bytes from RX, issues one pipelined Wishbone
// transaction, and returns a status/data byte sequence over TX.
module wbu_cmd_master
   import wbu_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_rx_stb,
   input  logic [7:0]            i_rx_data,
   output logic                  o_tx_stb,
   output logic [7:0]            o_tx_data,
   input  logic                  i_tx_busy,
   output logic                  o_wb_cyc,
   output logic                  o_wb_stb,
   output logic                  o_wb_we,
   output logic [ADDR_WIDTH-1:0] o_wb_addr,
   output logic [31:0]           o_wb_data,
   input  logic                  i_wb_stall,
   input  logic                  i_wb_ack,
   input  logic [31:0]           i_wb_data,
   output logic                  o_busy,
   output logic                  o_overrun
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   wbu_state_e            state_q, state_d;
   logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [CW-1:0]         tmo_q, tmo_d;
   logic                  busy_q, ovr_q, ovr_d;
   logic                  cmpl_s, abort_s, tmo_hit_s;
   logic                  ld_s, done_s;
   logic [7:0]            ld_hdr_s;
   logic [31:0]           ld_word_s;
   logic [2:0]            ld_len_s;

   assign tmo_hit_s = (tmo_q == TMO_LAST);

   // Command parsing, bus sequencing and response queuing
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      cmpl_s    = 1'b0;
      abort_s   = 1'b0;
      ld_s      = 1'b0;
      ld_hdr_s  = RSP_ERR;
      ld_word_s = 32'h0000_0000;
      ld_len_s  = 3'd1;
      case (state_q)
         ST_IDLE: begin
            if (i_rx_stb) begin
               if (is_opcode(i_rx_data)) begin
                  we_d    = (i_rx_data == OP_WRITE);
                  state_d = ST_ADDR;
               end else begin
                  ld_s    = 1'b1;
                  state_d = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (i_rx_stb) begin
               addr_d = i_rx_data[ADDR_WIDTH-1:0];
               cnt_d  = 2'd0;
               tmo_d  = '0;
               if (we_q) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_BUS_REQ;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
               end
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (i_rx_stb) begin
               data_d = {data_q[23:0], i_rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_BUS_REQ;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  tmo_d   = '0;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_BUS_REQ: begin
            // An ack alongside acceptance completes the cycle immediately
            if (!i_wb_stall && i_wb_ack) begin
               cmpl_s = 1'b1;
            end else if (tmo_hit_s) begin
               abort_s = 1'b1;
            end else begin
               tmo_d = tmo_q + CW'(1);
               if (!i_wb_stall) begin
                  stb_d   = 1'b0;
                  state_d = ST_BUS_WAIT;
               end else begin
                  state_d = ST_BUS_REQ;
               end
            end
         end
         ST_BUS_WAIT: begin
            if (i_wb_ack) begin
               cmpl_s = 1'b1;
            end else if (tmo_hit_s) begin
               abort_s = 1'b1;
            end else begin
               tmo_d = tmo_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (cmpl_s) begin
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         ld_s    = 1'b1;
         state_d = ST_RESP;
         if (we_q) begin
            ld_hdr_s = RSP_ACK;
         end else begin
            ld_hdr_s  = RSP_READ;
            ld_word_s = i_wb_data;
            ld_len_s  = 3'd5;
         end
      end else if (abort_s) begin
         cyc_d    = 1'b0;
         stb_d    = 1'b0;
         ld_s     = 1'b1;
         ld_hdr_s = RSP_TMO;
         state_d  = ST_RESP;
      end else begin
         ld_s = ld_s;
      end

      // RX bytes arriving while a transaction or response is active are dropped
      if (i_rx_stb && ((state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT) ||
                       (state_q == ST_RESP))) begin
         ovr_d = 1'b1;
      end else begin
         ovr_d = 1'b0;
      end
   end

   // Control and bus registers; reset abandons any in-flight cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= 32'h0000_0000;
         cnt_q   <= 2'd0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         busy_q  <= (state_d != ST_IDLE);
         ovr_q   <= ovr_d;
      end
   end

   wbu_resp_serializer u_resp (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (ld_s),
      .i_hdr     (ld_hdr_s),
      .i_word    (ld_word_s),
      .i_len     (ld_len_s),
      .i_tx_busy (i_tx_busy),
      .o_tx_stb  (o_tx_stb),
      .o_tx_data (o_tx_data),
      .o_done    (done_s)
   );

   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_we   = we_q;
   assign o_wb_addr = addr_q;
   assign o_wb_data = data_q;
   assign o_busy    = busy_q;
   assign o_overrun = ovr_q;

endmodule

// File: tb/tb_wbu_cmd_master.sv
// Self-checking bench for wbu_cmd_master: directed scenarios followed by
// randomized commands, all judged against a transaction-level model.
module tb_wbu_cmd_master;

   localparam int AW  = 4;
   localparam int TMO = 16;

   logic          clk;
   logic          i_reset;
   logic          i_rx_stb;
   logic [7:0]    i_rx_data;
   logic          o_tx_stb;
   logic [7:0]    o_tx_data;
   logic          i_tx_busy;
   logic          o_wb_cyc, o_wb_stb, o_wb_we;
   logic [AW-1:0] o_wb_addr;
   logic [31:0]   o_wb_data;
   logic          i_wb_stall, i_wb_ack;
   logic [31:0]   i_wb_data;
   logic          o_busy, o_overrun;

   wbu_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
      .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
      .o_busy(o_busy), .o_overrun(o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // stimulus / environment state
   logic [7:0]  cmd_q[$];
   logic [7:0]  tx_got[$];
   logic [7:0]  exp_tx[$];
   bit          rx_pend, rst_pend, force_ack, ack_pend, respond, stb_seen;
   logic [7:0]  rx_byte;
   int          busy_pct, stall_left, cur_stalls, exp_ovr;
   logic [31:0] slv_rdata;
   int          stb_cycles, cyc_cycles, unstable, ovr_pulses;
   logic [31:0] rec_addr, rec_data;
   logic        rec_we;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: observe outputs, play slave and TX sink, drive next inputs
   task automatic step();
      @(posedge clk);
      #1;
      if (o_overrun) ovr_pulses++;
      if (o_wb_cyc) cyc_cycles++;
      i_wb_ack  = ack_pend | force_ack;
      force_ack = 1'b0;
      ack_pend  = 1'b0;
      i_wb_data = slv_rdata;
      if (o_wb_stb) begin
         stb_cycles++;
         if (!stb_seen) begin
            stb_seen = 1'b1;
            rec_addr = 32'(o_wb_addr);
            rec_we   = o_wb_we;
            rec_data = o_wb_data;
         end else if (32'(o_wb_addr) !== rec_addr || o_wb_we !== rec_we || o_wb_data !== rec_data) begin
            unstable++;
         end
         if (stall_left > 0) begin
            i_wb_stall = 1'b1;
            stall_left--;
         end else begin
            i_wb_stall = 1'b0;
            ack_pend   = respond;
         end
      end else begin
         i_wb_stall = 1'b0;
      end
      i_tx_busy = (int'($urandom_range(99)) < busy_pct);
      if (o_tx_stb && !i_tx_busy) tx_got.push_back(o_tx_data);
      i_rx_stb  = rx_pend;
      i_rx_data = rx_byte;
      rx_pend   = 1'b0;
      i_reset   = rst_pend;
      rst_pend  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_pend = 1'b1;
      rx_byte = b;
      step();
   endtask

   task automatic start_cmd(input int stalls, input bit resp, input logic [31:0] rdata, input int bpct);
      tx_got.delete();
      stb_cycles = 0; cyc_cycles = 0; unstable = 0; ovr_pulses = 0;
      stb_seen = 1'b0; exp_ovr = 0;
      stall_left = stalls; cur_stalls = stalls; respond = resp;
      slv_rdata = rdata; busy_pct = bpct;
      foreach (cmd_q[i]) send_byte(cmd_q[i]);
   endtask

   // Reference: what a command should produce, from the command rules alone
   task automatic finish_cmd(input string name);
      int n;
      logic [7:0]  op;
      bit          exp_bus, exp_we;
      logic [31:0] exp_addr, exp_data;
      n = 0;
      step();
      while (o_busy && n < 400) begin
         step();
         n++;
      end
      check({name, ".idle"}, 32'(o_busy), 32'd0);
      step();
      busy_pct = 0;

      exp_tx.delete();
      op       = cmd_q[0];
      exp_bus  = (op == 8'h57) || (op == 8'h52);
      exp_we   = (op == 8'h57);
      exp_addr = 0;
      exp_data = 0;
      if (!exp_bus) begin
         exp_tx.push_back(8'h3F);
      end else begin
         exp_addr = 32'(cmd_q[1]) % (1 << AW);
         if (exp_we)
            exp_data = 32'(cmd_q[2]) * 32'h0100_0000 + 32'(cmd_q[3]) * 32'h0001_0000 +
                       32'(cmd_q[4]) * 32'h0000_0100 + 32'(cmd_q[5]);
         if (!respond) begin
            exp_tx.push_back(8'h54);
         end else if (exp_we) begin
            exp_tx.push_back(8'h4B);
         end else begin
            exp_tx.push_back(8'h52);
            for (int k = 3; k >= 0; k--) exp_tx.push_back(8'((slv_rdata >> (8 * k)) & 32'hFF));
         end
      end

      check({name, ".tx_count"}, 32'(tx_got.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
         check($sformatf("%s.tx_byte%0d", name, i), 32'(tx_got[i]), 32'(exp_tx[i]));
      if (exp_bus) begin
         check({name, ".stb_cycles"}, 32'(stb_cycles), 32'(cur_stalls + 1));
         check({name, ".cyc_cycles"}, 32'(cyc_cycles), respond ? 32'(cur_stalls + 2) : 32'(TMO));
         check({name, ".addr"}, rec_addr, exp_addr);
         check({name, ".we"}, 32'(rec_we), 32'(exp_we));
         if (exp_we) check({name, ".wdata"}, rec_data, exp_data);
         check({name, ".stable"}, 32'(unstable), 32'd0);
      end else begin
         check({name, ".no_bus"}, 32'(stb_cycles + cyc_cycles), 32'd0);
      end
      check({name, ".overrun"}, 32'(ovr_pulses), 32'(exp_ovr));
   endtask

   task automatic check_reset_values(input string name);
      check({name, ".cyc_stb_we"}, {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
      check({name, ".addr"}, 32'(o_wb_addr), 32'd0);
      check({name, ".wdata"}, o_wb_data, 32'd0);
      check({name, ".tx"}, {23'd0, o_tx_stb, o_tx_data}, 32'd0);
      check({name, ".busy_ovr"}, {30'd0, o_busy, o_overrun}, 32'd0);
   endtask

   initial begin
      i_reset = 1'b1; i_rx_stb = 1'b0; i_rx_data = 8'h00; i_tx_busy = 1'b0;
      i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = 32'h0;
      rx_pend = 0; rst_pend = 1; force_ack = 0; ack_pend = 0; respond = 1;
      rx_byte = 8'h00; busy_pct = 0; stall_left = 0; slv_rdata = 0;
      step();
      step();
      check_reset_values("reset");

      // Write with latency checks: stb one cycle after last byte, TX two later
      cmd_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      start_cmd(0, 1'b1, 32'h0, 0);
      step();
      check("lat.stb_n1", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
      step();
      check("lat.wait_n2", {30'd0, o_wb_cyc, o_wb_stb}, 32'd2);
      step();
      check("lat.tx_n3", {23'd0, o_tx_stb, o_tx_data}, 32'h14B);
      check("lat.cyc_n3", 32'(o_wb_cyc), 32'd0);
      finish_cmd("write1");

      // Read returning 3
      cmd_q = '{8'h52, 8'h00};
      start_cmd(0, 1'b1, 32'h0000_0003, 0);
      finish_cmd("read3");

      // Write, then a stalled write
      cmd_q = '{8'h57, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      start_cmd(0, 1'b1, 32'h0, 0);
      finish_cmd("write_a");
      cmd_q = '{8'h57, 8'h0C, 8'h12, 8'h34, 8'h56, 8'h78};
      start_cmd(10, 1'b1, 32'h0, 0);
      finish_cmd("write_stall");

      // No ack: timeout, then a late ack must not produce anything
      cmd_q = '{8'h52, 8'h03};
      start_cmd(0, 1'b0, 32'hCAFE_F00D, 0);
      finish_cmd("timeout");
      tx_got.delete();
      force_ack = 1'b1;
      step(); step(); step();
      check("late_ack.tx", 32'(tx_got.size()), 32'd0);
      check("late_ack.idle", {30'd0, o_busy, o_wb_cyc}, 32'd0);

      // Bad opcode, plus an RX byte dropped while TX is held busy
      cmd_q = '{8'h41};
      start_cmd(0, 1'b1, 32'h0, 100);
      step();
      send_byte(8'h57);
      busy_pct = 0;
      exp_ovr  = 1;
      finish_cmd("err_overrun");
      cmd_q = '{8'h52, 8'h01};
      start_cmd(0, 1'b1, 32'h8001_7F10, 0);
      finish_cmd("after_overrun");

      // Reset after three write data bytes
      cmd_q = '{8'h57, 8'h3A, 8'h11, 8'h22, 8'h33};
      start_cmd(0, 1'b1, 32'h0, 0);
      check("pre_reset.busy", 32'(o_busy), 32'd1);
      rst_pend = 1'b1;
      step();
      step();
      check_reset_values("mid_reset");
      cmd_q = '{8'h52, 8'h00};
      start_cmd(0, 1'b1, 32'h0102_0304, 0);
      finish_cmd("post_reset_read");

      // Randomized commands
      for (int t = 0; t < 24; t++) begin
         int kind;
         logic [7:0] b;
         kind = int'($urandom_range(9));
         cmd_q.delete();
         if (kind < 5) begin
            cmd_q.push_back(8'h57);
            for (int k = 0; k < 5; k++) cmd_q.push_back(8'($urandom_range(255)));
         end else if (kind < 9) begin
            cmd_q.push_back(8'h52);
            cmd_q.push_back(8'($urandom_range(255)));
         end else begin
            b = 8'($urandom_range(255));
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            cmd_q.push_back(b);
         end
         start_cmd(int'($urandom_range(6)), ($urandom_range(9) != 0), $urandom, int'($urandom_range(40)));
         finish_cmd($sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
